fifo_buffer_flex: RTL and testbench

Parametrised synchronous FIFO, successor to the basic single-mode FIFO. It adds:
- a live fill count;
- programmable almost-full and almost-empty thresholds;
- a selectable show-ahead (first-word-fall-through) read mode;
- a synchronous flush;
- sticky overflow and underflow error flags.

It sits between producer and consumer pipeline stages on one clock domain. Depth is not restricted to powers of two.

---
 rtl/fifo_pkg.sv | 24 ++
 rtl/fifo_mem.sv | 35 +++
 rtl/fifo_buffer_flex.sv | 143 ++++++++++++++
 tb/tb_fifo_buffer_flex.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared helpers and read-mode encodings for fifo_buffer_flex.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

  // Read-mode encodings for the SHOW_AHEAD parameter
  localparam int REGISTERED = 0;
  localparam int SHOW_AHEAD = 1;

  // Width needed to hold an occupancy of 0..depth inclusive
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Pointer increment that wraps at depth-1, so any depth works
  function automatic int next_ptr(input int ptr, input int depth);
    return (ptr >= depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : fifo_mem
// Description : DEPTH x WIDTH register array, one write port, one
//               combinational read port, no reset on the storage.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             clock,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port: storage is deliberately left unreset
  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule
`default_nettype wire

// File: rtl/fifo_buffer_flex.sv
`default_nettype none
// ============================================================================
// Module      : fifo_buffer_flex
// Description : Synchronous FIFO with fill count, programmable almost-full /
//               almost-empty thresholds, registered or show-ahead read,
//               synchronous flush and sticky overflow/underflow flags.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_buffer_flex
  import fifo_pkg::*;
#(
  parameter int BUFFER_SIZE      = 16,
  parameter int DATA_WIDTH       = 8,
  parameter int SHOW_AHEAD       = 0,
  parameter int ALMOST_FULL_LVL  = 14,
  parameter int ALMOST_EMPTY_LVL = 2,
  localparam int CNT_W           = cnt_width(BUFFER_SIZE)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  input  logic                  flush,
  input  logic                  clear_err,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  val,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [CNT_W-1:0]      count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int PTR_W = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1;

  // Parameter range checks at elaboration
  if (BUFFER_SIZE < 2) begin : g_chk_size
    $error("fifo_buffer_flex: BUFFER_SIZE must be >= 2");
  end
  if (DATA_WIDTH < 1) begin : g_chk_width
    $error("fifo_buffer_flex: DATA_WIDTH must be >= 1");
  end
  if (SHOW_AHEAD != fifo_pkg::REGISTERED && SHOW_AHEAD != fifo_pkg::SHOW_AHEAD) begin : g_chk_mode
    $error("fifo_buffer_flex: SHOW_AHEAD must be 0 or 1");
  end
  if (ALMOST_FULL_LVL < 1 || ALMOST_FULL_LVL > BUFFER_SIZE) begin : g_chk_af
    $error("fifo_buffer_flex: ALMOST_FULL_LVL out of range 1..BUFFER_SIZE");
  end
  if (ALMOST_EMPTY_LVL < 0 || ALMOST_EMPTY_LVL > BUFFER_SIZE - 1) begin : g_chk_ae
    $error("fifo_buffer_flex: ALMOST_EMPTY_LVL out of range 0..BUFFER_SIZE-1");
  end

  logic [PTR_W-1:0]      w_ptr;
  logic [PTR_W-1:0]      r_ptr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  pop_acc;
  logic                  push_acc;
  logic                  ovf_event;
  logic                  unf_event;

  // Status flags decode from the registered count only
  assign full         = (count == CNT_W'(BUFFER_SIZE));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CNT_W'(ALMOST_FULL_LVL));
  assign almost_empty = (count <= CNT_W'(ALMOST_EMPTY_LVL));

  // A pop frees a slot in the same cycle, so a full FIFO still takes a push
  assign pop_acc   = pop && !empty && !flush;
  assign push_acc  = push && (!full || pop_acc) && !flush;
  assign ovf_event = push && full && !pop && !flush;
  assign unf_event = pop && empty && !flush;

  fifo_mem #(
    .DEPTH (BUFFER_SIZE),
    .WIDTH (DATA_WIDTH),
    .AW    (PTR_W)
  ) u_mem (
    .clock (clock),
    .we    (push_acc),
    .waddr (w_ptr),
    .wdata (data_in),
    .raddr (r_ptr),
    .rdata (rd_data)
  );

  // Pointer and occupancy tracking; flush wins over push/pop
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      w_ptr <= '0;
      r_ptr <= '0;
      count <= '0;
    end else if (flush) begin
      w_ptr <= '0;
      r_ptr <= '0;
      count <= '0;
    end else begin
      if (push_acc) w_ptr <= PTR_W'(next_ptr(int'(w_ptr), BUFFER_SIZE));
      if (pop_acc)  r_ptr <= PTR_W'(next_ptr(int'(r_ptr), BUFFER_SIZE));
      case ({push_acc, pop_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags; a new error in the clearing cycle keeps the flag set
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ovf_event)      overflow <= 1'b1;
      else if (clear_err) overflow <= 1'b0;
      if (unf_event)      underflow <= 1'b1;
      else if (clear_err) underflow <= 1'b0;
    end
  end

  if (SHOW_AHEAD == fifo_pkg::SHOW_AHEAD) begin : g_show_ahead
    // Head word is presented directly; pop acknowledges it
    assign data_out = rd_data;
    assign val      = !empty;
  end else begin : g_registered
    // Accepted pop captures the head word and pulses val for one cycle
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        data_out <= '0;
        val      <= 1'b0;
      end else if (pop_acc) begin
        data_out <= rd_data;
        val      <= 1'b1;
      end else begin
        val      <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_buffer_flex.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_buffer_flex
// Description : Bench for fifo_buffer_flex: a depth-5 registered-read
//               instance and a depth-4 show-ahead instance share stimulus,
//               each compared against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_buffer_flex;

  logic       clk = 1'b0;
  logic       reset;
  logic       push, pop, flush, clear_err;
  logic [7:0] data_in;

  logic [7:0] dout0, dout1;
  logic       val0, full0, empty0, af0, ae0, ovf0, unf0;
  logic       val1, full1, empty1, af1, ae1, ovf1, unf1;
  logic [2:0] count0, count1;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  bit         m_ovf0, m_unf0, m_ovf1, m_unf1;
  bit         m_val0;
  logic [7:0] m_dout0;

  always #5 clk = ~clk;

  fifo_buffer_flex #(
    .BUFFER_SIZE(5), .DATA_WIDTH(8), .SHOW_AHEAD(0),
    .ALMOST_FULL_LVL(4), .ALMOST_EMPTY_LVL(1)
  ) dut0 (
    .clock(clk), .reset(reset), .push(push), .data_in(data_in), .pop(pop),
    .flush(flush), .clear_err(clear_err), .data_out(dout0), .val(val0),
    .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
    .count(count0), .overflow(ovf0), .underflow(unf0)
  );

  fifo_buffer_flex #(
    .BUFFER_SIZE(4), .DATA_WIDTH(8), .SHOW_AHEAD(1),
    .ALMOST_FULL_LVL(3), .ALMOST_EMPTY_LVL(1)
  ) dut1 (
    .clock(clk), .reset(reset), .push(push), .data_in(data_in), .pop(pop),
    .flush(flush), .clear_err(clear_err), .data_out(dout1), .val(val1),
    .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
    .count(count1), .overflow(ovf1), .underflow(unf1)
  );

  // Watchdog so the run always ends
  initial begin
    #2ms;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // What the FIFO rules say happens to one request set at a given occupancy
  function automatic void decide(input int n, input int depth,
                                 input bit pu, input bit po, input bit fl,
                                 output bit push_ok, output bit pop_ok,
                                 output bit ovf_ev, output bit unf_ev);
    push_ok = 0; pop_ok = 0; ovf_ev = 0; unf_ev = 0;
    if (!fl) begin
      pop_ok  = po && (n > 0);
      push_ok = pu && ((n < depth) || pop_ok);
      ovf_ev  = pu && (n == depth) && !po;
      unf_ev  = po && (n == 0);
    end
  endfunction

  task automatic model_update(input bit pu, input bit po, input bit fl,
                              input bit cl, input logic [7:0] d);
    bit pk, ok, oe, ue;
    decide(q0.size(), 5, pu, po, fl, pk, ok, oe, ue);
    m_val0 = 0;
    if (ok) begin m_dout0 = q0.pop_front(); m_val0 = 1; end
    if (pk) q0.push_back(d);
    if (fl) q0.delete();
    m_ovf0 = oe ? 1'b1 : (cl ? 1'b0 : m_ovf0);
    m_unf0 = ue ? 1'b1 : (cl ? 1'b0 : m_unf0);

    decide(q1.size(), 4, pu, po, fl, pk, ok, oe, ue);
    if (ok) void'(q1.pop_front());
    if (pk) q1.push_back(d);
    if (fl) q1.delete();
    m_ovf1 = oe ? 1'b1 : (cl ? 1'b0 : m_ovf1);
    m_unf1 = ue ? 1'b1 : (cl ? 1'b0 : m_unf1);
  endtask

  task automatic model_reset();
    q0.delete(); q1.delete();
    m_ovf0 = 0; m_unf0 = 0; m_ovf1 = 0; m_unf1 = 0;
    m_val0 = 0; m_dout0 = 8'h00;
  endtask

  task automatic check_all();
    check("count0", int'(count0), q0.size());
    check("full0",  int'(full0),  int'(q0.size() == 5));
    check("empty0", int'(empty0), int'(q0.size() == 0));
    check("af0",    int'(af0),    int'(q0.size() >= 4));
    check("ae0",    int'(ae0),    int'(q0.size() <= 1));
    check("ovf0",   int'(ovf0),   int'(m_ovf0));
    check("unf0",   int'(unf0),   int'(m_unf0));
    check("val0",   int'(val0),   int'(m_val0));
    check("dout0",  int'(dout0),  int'(m_dout0));
    check("count1", int'(count1), q1.size());
    check("full1",  int'(full1),  int'(q1.size() == 4));
    check("empty1", int'(empty1), int'(q1.size() == 0));
    check("af1",    int'(af1),    int'(q1.size() >= 3));
    check("ae1",    int'(ae1),    int'(q1.size() <= 1));
    check("ovf1",   int'(ovf1),   int'(m_ovf1));
    check("unf1",   int'(unf1),   int'(m_unf1));
    check("val1",   int'(val1),   int'(q1.size() > 0));
    if (q1.size() > 0) check("dout1", int'(dout1), int'(q1[0]));
  endtask

  // One clock of requests, then compare both instances against the model
  task automatic step(input bit pu, input bit po, input bit fl,
                      input bit cl, input logic [7:0] d);
    push = pu; pop = po; flush = fl; clear_err = cl; data_in = d;
    @(posedge clk);
    model_update(pu, po, fl, cl, d);
    #1;
    push = 0; pop = 0; flush = 0; clear_err = 0;
    check_all();
  endtask

  initial begin
    reset = 1; push = 0; pop = 0; flush = 0; clear_err = 0; data_in = 8'h00;
    model_reset();
    #1;
    check_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0;

    // Fill the depth-5 instance, then overflow it
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 8'h11 + 8'(i));
    check("fill_count0", int'(count0), 5);
    check("fill_full0",  int'(full0), 1);
    step(1, 0, 0, 0, 8'h16);
    check("ovf_6th", int'(ovf0), 1);
    check("ovf_count0", int'(count0), 5);
    step(0, 0, 0, 1, 8'h00);

    // Push and pop together while full
    step(1, 1, 0, 0, 8'h20);
    check("full_pp_count0", int'(count0), 5);
    check("full_pp_ovf0", int'(ovf0), 0);
    check("full_pp_head", int'(dout0), 8'h11);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 8'h00);
    check("drain_last", int'(dout0), 8'h20);
    check("drain_empty0", int'(empty0), 1);
    step(0, 0, 0, 1, 8'h00);

    // Push and pop together while empty
    step(1, 1, 0, 0, 8'h33);
    check("empty_pp_count0", int'(count0), 1);
    check("empty_pp_unf0", int'(unf0), 1);
    check("empty_pp_val0", int'(val0), 0);
    step(0, 0, 0, 1, 8'h00);
    check("clr_unf0", int'(unf0), 0);

    // Show-ahead latency
    step(0, 0, 1, 0, 8'h00);
    step(1, 0, 0, 0, 8'hA5);
    check("sa_val1", int'(val1), 1);
    check("sa_dout1", int'(dout1), 8'hA5);
    step(0, 1, 0, 0, 8'h00);
    check("sa_empty1", int'(empty1), 1);
    check("sa_val1_off", int'(val1), 0);

    // Threshold walk on the depth-4 instance, then flush keeps error flags
    step(1, 0, 0, 0, 8'h01);
    step(1, 0, 0, 0, 8'h02);
    check("ae1_at2", int'(ae1), 0);
    step(1, 0, 0, 0, 8'h03);
    check("af1_at3", int'(af1), 1);
    step(1, 0, 0, 0, 8'h04);
    step(1, 0, 0, 0, 8'h05);
    check("ovf1_set", int'(ovf1), 1);
    step(0, 0, 1, 0, 8'h00);
    check("flush_count1", int'(count1), 0);
    check("flush_ae1", int'(ae1), 1);
    check("flush_ovf1", int'(ovf1), 1);
    check("flush_val0", int'(val0), 0);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45,
           $urandom_range(0, 31) == 0, $urandom_range(0, 15) == 0,
           8'($urandom));
    end

    // Asynchronous reset between edges with three words stored
    step(0, 0, 1, 0, 8'h00);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 8'h70 + 8'(i));
    step(0, 1, 0, 0, 8'h00);
    step(1, 0, 0, 0, 8'h73);
    #2;
    reset = 1;
    #1;
    model_reset();
    check("rst_count0", int'(count0), 0);
    check("rst_empty0", int'(empty0), 1);
    check("rst_val0", int'(val0), 0);
    check("rst_dout0", int'(dout0), 0);
    check_all();
    @(negedge clk);
    reset = 0;
    step(1, 0, 0, 0, 8'h44);
    step(0, 1, 0, 0, 8'h00);
    check("post_rst_dout0", int'(dout0), 8'h44);
    check("post_rst_val0", int'(val0), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
